// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START     = 1'b0;
  localparam logic PS2_STOP      = 1'b1;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for both PS/2 lines plus a run-length glitch filter
// on the clock line that yields a one-cycle falling-edge strobe.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic [CW-1:0] cnt;

  assign data_sync = dat_s[1];

  // cnt tops out at FILTER_LEN-1: the next differing sample flips the
  // filtered level and restarts the run, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s    <= 2'b11;
      dat_s    <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      fall  <= 1'b0;
      if (clk_s[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s[1];
        cnt      <= '0;
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start/8 data/odd parity/stop, with an
// inter-edge timeout. bsy falling marks a fresh byte on data_out.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       bsy,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_filt, fall_raw, fall, din;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_filt  (clk_filt),
    .fall      (fall_raw),
    .data_sync (din)
  );

  // The strobe is registered alongside the new low level, so both agree.
  assign fall = fall_raw & ~clk_filt;

  ps2_state_t              state, state_n;
  logic [2:0]              bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
  logic                    par, par_n;
  logic [TW-1:0]           to_cnt, to_cnt_n;
  logic [7:0]              data_out_n;
  logic                    bsy_n, frame_err_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      data_out  <= '0;
      bsy       <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      to_cnt    <= to_cnt_n;
      data_out  <= data_out_n;
      bsy       <= bsy_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    par_n       = par;
    to_cnt_n    = to_cnt;
    data_out_n  = data_out;
    bsy_n       = bsy;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        to_cnt_n = '0;
        if (fall && din == PS2_START) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          bsy_n     = 1'b1;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n = {din, shreg[PS2_DATA_BITS-1:1]};
          if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
          else                                  bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = din;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (din == PS2_STOP && ps2_odd_ok(shreg, par)) begin
            data_out_n = shreg;
            bsy_n      = 1'b0;
          end else begin
            frame_err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // An edge arriving in the expiry cycle takes precedence over the abort.
    if (state != IDLE) begin
      if (fall) begin
        to_cnt_n = '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
        to_cnt_n    = '0;
        frame_err_n = 1'b1;
        state_n     = IDLE;
      end else begin
        to_cnt_n = to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames plus reset, spurious-edge,
// timeout and mid-frame reset sequences.
module tb_ps2_rx;

  localparam int F = 8;
  localparam int T = 2000;
  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       bsy, frame_err;

  always #5 clk = ~clk;

  ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_out  (data_out),
    .bsy       (bsy),
    .frame_err (frame_err)
  );

  int pass_cnt = 0, tot_cnt = 0;
  int err_cnt = 0, err_run = 0, err_max = 0;

  always @(negedge clk) begin
    if (frame_err) begin
      if (err_run == 0) err_cnt++;
      err_run++;
    end else begin
      if (err_run > err_max) err_max = err_run;
      err_run = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock phase of H cycles; optional opposite-level glitch of F-1 cycles.
  task automatic phase(input bit lvl, input bit glitch, output int lat);
    ps2_clk = lvl;
    lat = 0;
    for (int i = 1; i <= H; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && (!bsy || frame_err)) lat = i;
      if (glitch && i == 20)         ps2_clk = ~lvl;
      if (glitch && i == 20 + F - 1) ps2_clk = lvl;
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch, output int lat);
    int dummy;
    ps2_data = b;
    phase(1'b1, glitch, dummy);
    phase(1'b0, glitch, lat);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop,
                            input bit glitch, output int lat, output bit sb,
                            output logic [7:0] so);
    int l;
    logic p;
    send_bit(1'b0, glitch, l);
    sb = bsy;
    so = data_out;
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch, l);
    p = par_ok ? ~^d : ^d;
    send_bit(p, glitch, l);
    send_bit(stop, glitch, lat);
    ps2_data = 1'b1;
    phase(1'b1, 1'b0, l);
    phase(1'b1, 1'b0, l);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop;
    bit         glitch;
    logic [7:0] exp_out;
    bit         exp_bsy;
    int         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         lat, e0, n, l;
    bit         sb;
    logic [7:0] so, prev_out;

    vecs[0] = '{8'h15, 1, 1, 0, 8'h15, 0, 0};
    vecs[1] = '{8'h33, 1, 1, 0, 8'h33, 0, 0};
    vecs[2] = '{8'hF0, 0, 1, 0, 8'h33, 1, 1};
    vecs[3] = '{8'h1C, 1, 1, 1, 8'h1C, 0, 0};
    vecs[4] = '{8'hA5, 1, 0, 0, 8'h1C, 1, 1};
    vecs[5] = '{8'h00, 1, 1, 0, 8'h00, 0, 0};
    vecs[6] = '{8'hFF, 1, 1, 1, 8'hFF, 0, 0};

    // Line activity while held in reset must not leak through.
    send_frame(8'h15, 1, 1, 0, lat, sb, so);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_bsy", bsy, 1);
    chk("rst_frame_err", err_cnt, 0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    prev_out = 8'h00;
    for (int r = 0; r < 7; r++) begin
      e0 = err_cnt;
      send_frame(vecs[r].d, vecs[r].par_ok, vecs[r].stop, vecs[r].glitch, lat, sb, so);
      chk($sformatf("v%0d_start_bsy", r), sb, 1);
      chk($sformatf("v%0d_start_hold", r), so, prev_out);
      chk($sformatf("v%0d_latency", r), lat, F + 3);
      chk($sformatf("v%0d_data_out", r), data_out, vecs[r].exp_out);
      chk($sformatf("v%0d_bsy", r), bsy, vecs[r].exp_bsy);
      chk($sformatf("v%0d_err", r), err_cnt - e0, vecs[r].exp_err);
      prev_out = vecs[r].exp_out;
    end

    // Falling clock with data high in IDLE is ignored.
    e0 = err_cnt;
    send_bit(1'b1, 1'b0, l);
    phase(1'b1, 1'b0, l);
    chk("spur_err", err_cnt - e0, 0);
    chk("spur_bsy", bsy, 0);
    chk("spur_data_out", data_out, 8'hFF);

    // Abandon a frame after four data bits.
    e0 = err_cnt;
    send_bit(1'b0, 1'b0, l);
    send_bit(1'b1, 1'b0, l);
    send_bit(1'b0, 1'b0, l);
    send_bit(1'b1, 1'b0, l);
    send_bit(1'b0, 1'b0, l);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    n = 0;
    for (int i = 1; i <= T + 200; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        n = i;
        break;
      end
    end
    chk("to_seen", (n != 0) ? 1 : 0, 1);
    chk("to_window", (n >= T - 30 && n <= T - 26) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("to_err_count", err_cnt - e0, 1);
    chk("to_bsy", bsy, 1);
    chk("to_data_out", data_out, 8'hFF);

    e0 = err_cnt;
    send_frame(8'h15, 1, 1, 0, lat, sb, so);
    chk("post_to_data_out", data_out, 8'h15);
    chk("post_to_bsy", bsy, 0);
    chk("post_to_err", err_cnt - e0, 0);

    // Reset in the middle of a frame.
    send_bit(1'b0, 1'b0, l);
    send_bit(1'b1, 1'b0, l);
    send_bit(1'b0, 1'b0, l);
    ps2_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e0 = err_cnt;
    rst = 1'b0;
    #1;
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_bsy", bsy, 1);
    chk("mid_rst_frame_err", frame_err, 0);
    repeat (5) @(posedge clk);
    rst = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("after_rst_data_out", data_out, 8'h00);
    chk("after_rst_bsy", bsy, 1);
    chk("after_rst_err", err_cnt - e0, 0);

    chk("err_pulse_width", err_max, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver, upstream of the busy-flag byte latch in the keyboard path. It synchronises and de-glitches the raw `ps2_clk`/`ps2_data` lines and deserialises each 11-bit frame. It checks start, odd parity and stop, then presents the byte on `data_out`. `bsy` is high while no fresh valid byte is available; the falling edge of `bsy` tells the downstream latch to capture `data_out`.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised `ps2_clk` samples needed before the filtered clock changes.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a filtered falling edge mid-frame before the frame is aborted.
- `clk`  in  1  system clock; must be at least 8× `FILTER_LEN` × the PS/2 clock rate.
- `rst`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `data_out`  out  8  last valid received byte.
- `bsy`  out  1  high = frame in progress or no valid byte yet; low = `data_out` valid.
- `frame_err`  out  1  one-cycle pulse on parity error, stop error or timeout.

## Operation
- Reset values while `rst` is low: `data_out` = 0x00, `bsy` = 1, `frame_err` = 0, state IDLE, all counters 0, filtered clock and synchronisers = 1.
- Input conditioning:
  - Both lines pass through 2-FF synchronisers.
  - Filtered `ps2_clk` toggles only after `FILTER_LEN` consecutive samples differ from its current value.
  - A falling edge of filtered `ps2_clk` (`fall`) is a one-cycle strobe.
  - `ps2_data` is sampled, synchronised, in the cycle `fall` is asserted.
- State machine:
  - IDLE: on `fall` with data = 0 → DATA, `bit_cnt` = 0, `bsy` ← 1. On `fall` with data = 1 → stay IDLE (spurious edge ignored, no error).
  - DATA: on each `fall`, shift data into `shreg` LSB-first and increment `bit_cnt`. After the 8th bit → PARITY.
  - PARITY: on `fall`, store the parity bit → STOP.
  - STOP: on `fall`, the frame is valid if stop = 1 and XOR(`shreg`, parity) = 1 (odd parity).
    - Valid: `data_out` ← `shreg`, `bsy` ← 0.
    - Invalid: `frame_err` pulses; `data_out` is held and `bsy` stays 1.
    - Either way → IDLE.
- Timeout: in DATA/PARITY/STOP, `to_cnt` counts `clk` cycles since the last `fall`.
  - When `to_cnt` reaches `TIMEOUT_CYCLES`: `frame_err` pulses, → IDLE, `bsy` stays 1.
  - `to_cnt` clears on every `fall` and is held at 0 in IDLE.
- `bsy` falls only on a valid frame. It stays low until the start bit of the next frame.
- `data_out` changes only at the same edge where `bsy` falls. It is therefore stable whenever `bsy` is low.
- Asynchronous reset mid-frame discards the partial frame immediately and returns every output to its reset value.

## Timing
- `fall` lags the raw `ps2_clk` falling edge by 2 synchroniser cycles plus `FILTER_LEN` cycles.
- `data_out`/`bsy` update on the `clk` edge following the `fall` of the stop bit. Total latency from the raw stop-bit edge is `FILTER_LEN` + 3 cycles.
- `frame_err` is high for exactly one `clk` cycle per error. Timeout and a `fall` in the same cycle: `fall` wins, and the timeout counter clears.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.
- The filter counter saturates; it does not wrap. `bit_cnt` is 3 bits and never wraps during a frame.
- The `to_cnt` width is $clog2(`TIMEOUT_CYCLES`+1).

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_state_t` {IDLE, DATA, PARITY, STOP};
  - constants `PS2_DATA_BITS` = 8, `PS2_START` = 0, `PS2_STOP` = 1.
- Sub-module `ps2_sync_filter`:
  - synchroniser and glitch filter;
  - outputs filtered clock, the `fall` strobe and synchronised data.
- The FSM, shift register, parity check and timeout live in `ps2_rx`.

## Test plan
- Reset: hold `rst` = 0 with line activity → `data_out` = 0x00, `bsy` = 1, `frame_err` = 0.
- Valid frame 0x15 (data LSB-first, parity 0, stop 1) → `bsy` falls; `data_out` = 0x15 at stop-edge latency; no `frame_err`.
- Valid frame 0x33 (parity 1), then start of a new frame → `data_out` = 0x33 with `bsy` low. At the next start bit `bsy` rises and `data_out` holds 0x33.
- Frame 0xF0 with parity forced to 0 → `frame_err` one-cycle pulse; `bsy` stays 1; `data_out` unchanged.
- Glitch pulses of `FILTER_LEN`−1 cycles on `ps2_clk` inside frame 0x1C → received cleanly as 0x1C.
- Frame stopped after 4 data bits → `frame_err` after `TIMEOUT_CYCLES`; a following 0x15 frame is received correctly. Reset asserted mid-frame → immediate reset values, and no byte is delivered.
